// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_pkg : shared pipeline definitions (register ids, hazard FSM)
// Revision: 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W           = 5;
    localparam int WAIT_CNT_W          = 8;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(input logic memread, input reg_idx_t rd,
                                          input reg_idx_t rs, input reg_idx_t rt);
        return memread && (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : pipeline status in, stage stall/flush controls out
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    reg_idx_t    id_rs_i;
    reg_idx_t    id_rt_i;
    reg_idx_t    ex_rd_i;
    logic        ex_memread_i;
    logic        branch_taken_i;
    logic        mem_req_i;
    logic        mem_ack_i;

    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        id_ex_stall_o;
    logic        ex_mem_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        mem_wb_flush_o;
    logic        state_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, ex_rd_i, ex_memread_i, branch_taken_i,
               mem_req_i, mem_ack_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
               state_o, err_o, stall_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, ex_rd_i, ex_memread_i, branch_taken_i,
               mem_req_i, mem_ack_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
               state_o, err_o, stall_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter16.sv
`default_nettype none
// ============================================================================
// sat_counter16 : 16-bit up counter that holds at all-ones
// Revision: 1.0
// ============================================================================
module sat_counter16 (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        inc,
    output      logic [15:0] count
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : memory-wait FSM plus load-use / branch hazard resolution
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input wire logic          clk_i,
    input wire logic          rst_i,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);

    hz_state_e             state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  err;
    logic                  memstall;
    logic                  loaduse;

    // Stall releases in the same cycle ack is seen, and also on the timeout cycle.
    always_comb begin
        if (state == ST_RUN) begin
            memstall = hz.mem_req_i && !hz.mem_ack_i;
        end else begin
            memstall = !hz.mem_ack_i && (wait_cnt < TIMEOUT_V);
        end
        loaduse = load_use_hit(hz.ex_memread_i, hz.ex_rd_i, hz.id_rs_i, hz.id_rt_i);
    end

    always_comb begin
        hz.pc_stall_o     = 1'b0;
        hz.if_id_stall_o  = 1'b0;
        hz.id_ex_stall_o  = 1'b0;
        hz.ex_mem_stall_o = 1'b0;
        hz.if_id_flush_o  = 1'b0;
        hz.id_ex_flush_o  = 1'b0;
        hz.mem_wb_flush_o = 1'b0;
        if (memstall) begin
            hz.pc_stall_o     = 1'b1;
            hz.if_id_stall_o  = 1'b1;
            hz.id_ex_stall_o  = 1'b1;
            hz.ex_mem_stall_o = 1'b1;
            hz.mem_wb_flush_o = 1'b1;
        end else if (loaduse) begin
            hz.pc_stall_o     = 1'b1;
            hz.if_id_stall_o  = 1'b1;
            hz.id_ex_flush_o  = 1'b1;
        end else if (hz.branch_taken_i) begin
            hz.if_id_flush_o  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hz.mem_req_i && !hz.mem_ack_i) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (hz.mem_ack_i) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == TIMEOUT_V) begin
                        err   <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign hz.state_o = (state == ST_MEM_WAIT);
    assign hz.err_o   = err;

    sat_counter16 u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (hz.pc_stall_o),
        .count (hz.stall_cnt_o)
    );

endmodule
`default_nettype wire
